// File: rtl/ctrl_pipe_pkg.sv
// Shared control-word types, bubble constants and ALU control codes for the
// Execute/Memory/Writeback control pipeline.
package ctrl_pipe_pkg;

   localparam int ALU_CTRL_WIDTH = 3;

   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD      = 3'b000;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB      = 3'b001;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OP_010   = 3'b010;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OP_011   = 3'b011;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASS_A   = 3'b110;
   localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASS_IMM = 3'b111;

   // Full word: E slice, then the M and WB slices carried onward.
   typedef struct packed {
      logic                      valid;
      logic                      is_scalar;
      logic                      is_vec_scalar;
      logic                      use_imm;
      logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
      logic                      wr_mem_en;
      logic                      out_flag;
      logic                      result_sel;
      logic                      we_scalar;
      logic                      we_vector;
   } ctrlE_t;

   typedef struct packed {
      logic valid;
      logic wr_mem_en;
      logic out_flag;
      logic result_sel;
      logic we_scalar;
      logic we_vector;
   } ctrlM_t;

   typedef struct packed {
      logic valid;
      logic result_sel;
      logic we_scalar;
      logic we_vector;
   } ctrlW_t;

   localparam ctrlE_t BUBBLE_E = '0;
   localparam ctrlM_t BUBBLE_M = '0;
   localparam ctrlW_t BUBBLE_W = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline register with async active-low reset to a bubble value.
// Clear has priority over hold, so a flush always beats a stall.
module pipe_stage_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_hold,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_q <= RESET_VAL;
      else if (i_clear)
         r_q <= RESET_VAL;
      else if (!i_hold)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/control_pipeline.sv
// Carries the decoded control word through the E, M and W pipeline registers,
// applies stall/flush at the E boundary and counts retired instructions.
module control_pipeline
   import ctrl_pipe_pkg::ctrlE_t, ctrl_pipe_pkg::ctrlM_t, ctrl_pipe_pkg::ctrlW_t,
          ctrl_pipe_pkg::BUBBLE_E, ctrl_pipe_pkg::BUBBLE_M, ctrl_pipe_pkg::BUBBLE_W;
#(
   parameter int ALU_CTRL_WIDTH = ctrl_pipe_pkg::ALU_CTRL_WIDTH,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      validD,
   input  logic                      isScalarInstructionED,
   input  logic                      isVectorScalarOperationED,
   input  logic                      useInmediateED,
   input  logic [ALU_CTRL_WIDTH-1:0] aluControlED,
   input  logic                      writeToMemoryEnableMD,
   input  logic                      outFlagMD,
   input  logic                      resultSelectorWBD,
   input  logic                      writeEnableScalarWBD,
   input  logic                      writeEnableVectorWBD,
   input  logic                      stallE,
   input  logic                      flushE,
   output logic                      validE,
   output logic                      isScalarInstructionE,
   output logic                      isVectorScalarOperationE,
   output logic                      useInmediateE,
   output logic [ALU_CTRL_WIDTH-1:0] aluControlE,
   output logic                      writeEnableScalarE,
   output logic                      writeEnableVectorE,
   output logic                      validM,
   output logic                      writeToMemoryEnableM,
   output logic                      outFlagM,
   output logic                      writeEnableScalarM,
   output logic                      writeEnableVectorM,
   output logic                      validW,
   output logic                      resultSelectorW,
   output logic                      writeEnableScalarW,
   output logic                      writeEnableVectorW,
   output logic [COUNT_WIDTH-1:0]    retiredCount
);

   ctrlE_t w_e_d, r_e;
   ctrlM_t w_m_d, r_m;
   ctrlW_t w_w_d, r_w;
   logic [COUNT_WIDTH-1:0] r_retired;

   // An invalid decode slot loads a clean bubble rather than its raw fields.
   always_comb begin
      w_e_d = BUBBLE_E;
      if (validD) begin
         w_e_d.valid         = 1'b1;
         w_e_d.is_scalar     = isScalarInstructionED;
         w_e_d.is_vec_scalar = isVectorScalarOperationED;
         w_e_d.use_imm       = useInmediateED;
         w_e_d.alu_ctrl      = aluControlED;
         w_e_d.wr_mem_en     = writeToMemoryEnableMD;
         w_e_d.out_flag      = outFlagMD;
         w_e_d.result_sel    = resultSelectorWBD;
         w_e_d.we_scalar     = writeEnableScalarWBD;
         w_e_d.we_vector     = writeEnableVectorWBD;
      end
   end

   always_comb begin
      w_m_d            = BUBBLE_M;
      w_m_d.valid      = r_e.valid;
      w_m_d.wr_mem_en  = r_e.wr_mem_en;
      w_m_d.out_flag   = r_e.out_flag;
      w_m_d.result_sel = r_e.result_sel;
      w_m_d.we_scalar  = r_e.we_scalar;
      w_m_d.we_vector  = r_e.we_vector;

      w_w_d            = BUBBLE_W;
      w_w_d.valid      = r_m.valid;
      w_w_d.result_sel = r_m.result_sel;
      w_w_d.we_scalar  = r_m.we_scalar;
      w_w_d.we_vector  = r_m.we_vector;
   end

   pipe_stage_reg #(.WIDTH($bits(ctrlE_t)), .RESET_VAL(BUBBLE_E)) u_reg_e (
      .clk(clk), .rst_n(rst_n), .i_hold(stallE), .i_clear(flushE), .i_d(w_e_d), .o_q(r_e)
   );

   // A stalled E slot issues a bubble into M; flush alone lets E advance.
   pipe_stage_reg #(.WIDTH($bits(ctrlM_t)), .RESET_VAL(BUBBLE_M)) u_reg_m (
      .clk(clk), .rst_n(rst_n), .i_hold(1'b0), .i_clear(stallE), .i_d(w_m_d), .o_q(r_m)
   );

   pipe_stage_reg #(.WIDTH($bits(ctrlW_t)), .RESET_VAL(BUBBLE_W)) u_reg_w (
      .clk(clk), .rst_n(rst_n), .i_hold(1'b0), .i_clear(1'b0), .i_d(w_w_d), .o_q(r_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retired <= '0;
      else if (r_w.valid && (r_retired != {COUNT_WIDTH{1'b1}}))
         r_retired <= r_retired + COUNT_WIDTH'(1);
   end

   assign validE                   = r_e.valid;
   assign isScalarInstructionE     = r_e.is_scalar;
   assign isVectorScalarOperationE = r_e.is_vec_scalar;
   assign useInmediateE            = r_e.use_imm;
   assign aluControlE              = r_e.alu_ctrl;
   assign writeEnableScalarE       = r_e.we_scalar & r_e.valid;
   assign writeEnableVectorE       = r_e.we_vector & r_e.valid;

   assign validM                   = r_m.valid;
   assign writeToMemoryEnableM     = r_m.wr_mem_en & r_m.valid;
   assign outFlagM                 = r_m.out_flag & r_m.valid;
   assign writeEnableScalarM       = r_m.we_scalar & r_m.valid;
   assign writeEnableVectorM       = r_m.we_vector & r_m.valid;

   assign validW                   = r_w.valid;
   assign resultSelectorW          = r_w.result_sel;
   assign writeEnableScalarW       = r_w.we_scalar & r_w.valid;
   assign writeEnableVectorW       = r_w.we_vector & r_w.valid;

   assign retiredCount             = r_retired;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed plus randomized bench for control_pipeline against a
// per-instruction reference model and an in-order retirement queue.
module tb_control_pipeline;

   localparam int AW        = 3;
   localparam int CW        = 4;
   localparam int COUNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          validD = 1'b0;
   logic          isScalarInstructionED = 1'b0;
   logic          isVectorScalarOperationED = 1'b0;
   logic          useInmediateED = 1'b0;
   logic [AW-1:0] aluControlED = '0;
   logic          writeToMemoryEnableMD = 1'b0;
   logic          outFlagMD = 1'b0;
   logic          resultSelectorWBD = 1'b0;
   logic          writeEnableScalarWBD = 1'b0;
   logic          writeEnableVectorWBD = 1'b0;
   logic          stallE = 1'b0;
   logic          flushE = 1'b0;
   logic          validE, isScalarInstructionE, isVectorScalarOperationE, useInmediateE;
   logic [AW-1:0] aluControlE;
   logic          writeEnableScalarE, writeEnableVectorE;
   logic          validM, writeToMemoryEnableM, outFlagM, writeEnableScalarM, writeEnableVectorM;
   logic          validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW;
   logic [CW-1:0] retiredCount;

   control_pipeline #(.ALU_CTRL_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .validD(validD),
      .isScalarInstructionED(isScalarInstructionED),
      .isVectorScalarOperationED(isVectorScalarOperationED),
      .useInmediateED(useInmediateED), .aluControlED(aluControlED),
      .writeToMemoryEnableMD(writeToMemoryEnableMD), .outFlagMD(outFlagMD),
      .resultSelectorWBD(resultSelectorWBD), .writeEnableScalarWBD(writeEnableScalarWBD),
      .writeEnableVectorWBD(writeEnableVectorWBD), .stallE(stallE), .flushE(flushE),
      .validE(validE), .isScalarInstructionE(isScalarInstructionE),
      .isVectorScalarOperationE(isVectorScalarOperationE), .useInmediateE(useInmediateE),
      .aluControlE(aluControlE), .writeEnableScalarE(writeEnableScalarE),
      .writeEnableVectorE(writeEnableVectorE), .validM(validM),
      .writeToMemoryEnableM(writeToMemoryEnableM), .outFlagM(outFlagM),
      .writeEnableScalarM(writeEnableScalarM), .writeEnableVectorM(writeEnableVectorM),
      .validW(validW), .resultSelectorW(resultSelectorW),
      .writeEnableScalarW(writeEnableScalarW), .writeEnableVectorW(writeEnableVectorW),
      .retiredCount(retiredCount)
   );

   // Clock
   always #5 clk = ~clk;

   // One decoded instruction as the decode stage drove it (raw, ungated).
   typedef struct packed {
      logic          valid;
      logic          is_scalar;
      logic          is_vs;
      logic          use_imm;
      logic [AW-1:0] alu;
      logic          wtm;
      logic          out_flag;
      logic          res_sel;
      logic          we_s;
      logic          we_v;
   } instr_t;

   instr_t      d_in;
   instr_t      m_e, m_m, m_w;
   int          m_count;
   logic [2:0]  exp_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [8:0] exp_e(input instr_t x);
      return x.valid ? {1'b1, x.is_scalar, x.is_vs, x.use_imm, x.alu, x.we_s, x.we_v} : 9'd0;
   endfunction

   function automatic logic [4:0] exp_m(input instr_t x);
      return x.valid ? {1'b1, x.wtm, x.out_flag, x.we_s, x.we_v} : 5'd0;
   endfunction

   function automatic logic [3:0] exp_w(input instr_t x);
      return x.valid ? {1'b1, x.res_sel, x.we_s, x.we_v} : 4'd0;
   endfunction

   function automatic instr_t mk(input logic v, input logic [AW-1:0] alu, input logic sc,
                                 input logic wtm, input logic rs, input logic ws, input logic wv);
      instr_t x;
      x = '0;
      x.valid = v; x.alu = alu; x.is_scalar = sc;
      x.wtm = wtm; x.res_sel = rs; x.we_s = ws; x.we_v = wv;
      return x;
   endfunction

   function automatic instr_t rand_instr(input int valid_pct);
      instr_t x;
      x.valid    = ($urandom_range(0, 99) < valid_pct);
      x.is_scalar = 1'($urandom_range(0, 1));
      x.is_vs    = 1'($urandom_range(0, 1));
      x.use_imm  = 1'($urandom_range(0, 1));
      x.alu      = AW'($urandom_range(0, 7));
      x.wtm      = 1'($urandom_range(0, 1));
      x.out_flag = 1'($urandom_range(0, 1));
      x.res_sel  = 1'($urandom_range(0, 1));
      x.we_s     = 1'($urandom_range(0, 1));
      x.we_v     = 1'($urandom_range(0, 1));
      return x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_e"}, 64'({validE, isScalarInstructionE, isVectorScalarOperationE, useInmediateE,
                            aluControlE, writeEnableScalarE, writeEnableVectorE}), 64'(exp_e(m_e)));
      chk({tag, "_m"}, 64'({validM, writeToMemoryEnableM, outFlagM, writeEnableScalarM,
                            writeEnableVectorM}), 64'(exp_m(m_m)));
      chk({tag, "_w"}, 64'({validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW}),
          64'(exp_w(m_w)));
      chk({tag, "_cnt"}, 64'(retiredCount), 64'(m_count));
   endtask

   // Scoreboard: each retiring slot must match the oldest surviving instruction.
   task automatic check_retire(input string tag);
      if (m_w.valid) begin
         chk({tag, "_retq_nonempty"}, 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0)
            chk({tag, "_retire"}, 64'({resultSelectorW, writeEnableScalarW, writeEnableVectorW}),
                64'(exp_q.pop_front()));
      end
   endtask

   task automatic drive_d(input instr_t x);
      validD                    = x.valid;
      isScalarInstructionED     = x.is_scalar;
      isVectorScalarOperationED = x.is_vs;
      useInmediateED            = x.use_imm;
      aluControlED              = x.alu;
      writeToMemoryEnableMD     = x.wtm;
      outFlagMD                 = x.out_flag;
      resultSelectorWBD         = x.res_sel;
      writeEnableScalarWBD      = x.we_s;
      writeEnableVectorWBD      = x.we_v;
   endtask

   // One clock: drive D and hazards, advance the model by the stage rules, check.
   task automatic step(input string tag, input logic stall, input logic flush);
      instr_t n_e, n_m;
      drive_d(d_in);
      stallE = stall;
      flushE = flush;
      if (flush)      n_e = '0;
      else if (stall) n_e = m_e;
      else            n_e = d_in;
      n_m = stall ? instr_t'('0) : m_e;
      if (!flush && !stall && d_in.valid) exp_q.push_back({d_in.res_sel, d_in.we_s, d_in.we_v});
      if (flush && stall && m_e.valid && exp_q.size() != 0) exp_q.pop_back();
      if (m_w.valid && m_count < COUNT_MAX) m_count++;
      m_w = m_m;
      m_m = n_m;
      m_e = n_e;
      @(posedge clk);
      #1;
      check_outputs(tag);
      check_retire(tag);
   endtask

   task automatic bubbles(input string tag, input int n);
      d_in = '0;
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
   endtask

   // Reset: asserted away from the edge, checked 1ns later, released on a negedge.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      m_e = '0; m_m = '0; m_w = '0; m_count = 0;
      exp_q.delete();
      #1;
      check_outputs(tag);
      d_in = '0;
      drive_d(d_in);
      stallE = 1'b0;
      flushE = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      d_in = '0;
      m_e = '0; m_m = '0; m_w = '0; m_count = 0;

      apply_reset("reset");

      // Single scalar ADD: E at 1, M at 2, W at 3, counted at edge 4.
      d_in = mk(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("add_c1", 1'b0, 1'b0);
      chk("add_validE", 64'({validE, aluControlE}), 64'({1'b1, 3'b000}));
      d_in = '0;
      step("add_c2", 1'b0, 1'b0);
      chk("add_weSM", 64'(writeEnableScalarM), 64'(1));
      step("add_c3", 1'b0, 1'b0);
      chk("add_weSW", 64'(writeEnableScalarW), 64'(1));
      step("add_c4", 1'b0, 1'b0);
      chk("add_count", 64'(retiredCount), 64'(1));

      // Store followed by vector load.
      d_in = mk(1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step("st", 1'b0, 1'b0);
      d_in = mk(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step("ld", 1'b0, 1'b0);
      bubbles("st_ld_drain", 4);

      // Stall for two cycles with X in E; Y waits in D.
      d_in = mk(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("stall_x", 1'b0, 1'b0);
      d_in = mk(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step("stall_1", 1'b1, 1'b0);
      chk("stall_1_validM", 64'(validM), 64'(0));
      step("stall_2", 1'b1, 1'b0);
      chk("stall_2_aluE", 64'(aluControlE), 64'(3'b001));
      step("stall_rel", 1'b0, 1'b0);
      d_in = '0;
      step("stall_d1", 1'b0, 1'b0);
      chk("stall_x_at_w", 64'({validW, writeEnableScalarW}), 64'(2'b11));
      bubbles("stall_drain", 3);

      // Flush and stall together kill both E and the instruction in D.
      d_in = mk(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step("fs_a", 1'b0, 1'b0);
      d_in = mk(1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step("fs_both", 1'b1, 1'b1);
      chk("fs_valid", 64'({validE, validM}), 64'(2'b00));
      d_in = '0;
      bubbles("fs_drain", 4);

      // Invalid decode slot with enables driven high.
      d_in = mk(1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      d_in.out_flag = 1'b1;
      for (int i = 0; i < 5; i++) step("inv", 1'b0, 1'b0);
      bubbles("inv_drain", 3);

      // Randomized traffic with occasional stall/flush.
      for (int i = 0; i < 200; i++) begin
         logic st, fl;
         d_in = rand_instr(75);
         st = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 7) == 0);
         step("rand", st, fl);
      end
      bubbles("rand_drain", 4);
      chk("rand_q_empty", 64'(exp_q.size()), 64'(0));

      // Saturation: 20 retirements on a 4-bit counter.
      apply_reset("reset2");
      for (int i = 0; i < 20; i++) begin
         d_in = rand_instr(100);
         step("sat", 1'b0, 1'b0);
      end
      bubbles("sat_drain", 4);
      chk("sat_count", 64'(retiredCount), 64'(15));
      bubbles("sat_hold", 2);

      // Reset mid-stream clears every output at once.
      for (int i = 0; i < 3; i++) begin
         d_in = rand_instr(100);
         step("pre_rst", 1'b0, 1'b0);
      end
      apply_reset("mid_reset");
      d_in = rand_instr(100);
      step("post_rst", 1'b0, 1'b0);
      bubbles("post_rst_drain", 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
